// File: rtl/div_pkg.sv
`default_nettype none
// ============================================================================
// Module  : div_pkg
// Brief   : Shared types and constants for the sequential signed divider.
// Revision: 1.0 - initial release
// ============================================================================
package div_pkg;

  // Default operand/result width of the divider.
  localparam int c_DIV_WIDTH = 32;

  // Iteration counter width for the default width.
  localparam int c_DIV_CNT_W = $clog2(c_DIV_WIDTH);

  // Controller states.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    ITER = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4,
    DZ   = 3'd5
  } div_state_t;

endpackage
`default_nettype wire

// File: rtl/div_step.sv
`default_nettype none
// ============================================================================
// Module  : div_step
// Brief   : One combinational restoring shift-subtract iteration on
//           magnitudes. The partial remainder is widened by one bit so a
//           divisor of 2^(WIDTH-1) never loses its top bit.
// Revision: 1.0 - initial release
// ============================================================================
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = c_DIV_WIDTH
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic [WIDTH-1:0] quo_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic [WIDTH-1:0] quo_out
);

  logic [WIDTH:0]   w_shift;
  logic             w_ge;
  logic [WIDTH-1:0] w_diff;

  // Shift {rem,quo} left one place and trial-subtract the divisor.
  always_comb begin
    w_shift = {rem_in, quo_in[WIDTH-1]};
    w_ge    = (w_shift >= {1'b0, divisor});
    // When w_ge holds the true difference is below the divisor, so the
    // low WIDTH bits of the subtraction are exact.
    w_diff  = w_shift[WIDTH-1:0] - divisor;
    rem_out = w_ge ? w_diff : w_shift[WIDTH-1:0];
    quo_out = {quo_in[WIDTH-2:0], w_ge};
  end

endmodule
`default_nettype wire

// File: rtl/div_seq_unit.sv
`default_nettype none
// ============================================================================
// Module  : div_seq_unit
// Brief   : Multicycle signed divider (MIPS DIV). Latches operands on init,
//           divides magnitudes with a restoring loop, then applies signs:
//           quotient truncates toward zero, remainder follows the dividend.
//           Divide-by-zero short-circuits to a one-cycle exception pulse.
// Revision: 1.0 - initial release
// ============================================================================
module div_seq_unit
  import div_pkg::*;
#(
  parameter int WIDTH = c_DIV_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             init,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi,
  output logic             excessao,
  output logic             done,
  output logic             busy
);

  localparam int                 c_CNT_W    = $clog2(WIDTH);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(WIDTH - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

  div_state_t         r_state;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_div;
  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-1:0]   r_quo;
  logic [c_CNT_W-1:0] r_cnt;
  logic               r_sign_q;
  logic               r_sign_r;

  logic [WIDTH-1:0]   w_rem_next;
  logic [WIDTH-1:0]   w_quo_next;

  div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .rem_in  (r_rem),
    .quo_in  (r_quo),
    .divisor (r_div),
    .rem_out (w_rem_next),
    .quo_out (w_quo_next)
  );

  // Controller, operand latches, iteration datapath and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_div    <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_cnt    <= '0;
      r_sign_q <= 1'b0;
      r_sign_r <= 1'b0;
      lo       <= '0;
      hi       <= '0;
      excessao <= 1'b0;
      done     <= 1'b0;
      busy     <= 1'b0;
    end else begin
      done     <= 1'b0;
      excessao <= 1'b0;
      case (r_state)
        IDLE: begin
          if (init) begin
            r_a  <= a;
            r_b  <= b;
            busy <= 1'b1;
            if (b == '0) begin
              // Exception is flagged in the very next cycle; lo/hi untouched.
              r_state  <= DZ;
              excessao <= 1'b1;
              done     <= 1'b1;
            end else begin
              r_state <= PREP;
            end
          end
        end
        DZ: begin
          busy    <= 1'b0;
          r_state <= IDLE;
        end
        PREP: begin
          // Unsigned magnitudes; the most-negative value maps to 2^(WIDTH-1).
          r_quo    <= r_a[WIDTH-1] ? (-r_a) : r_a;
          r_div    <= r_b[WIDTH-1] ? (-r_b) : r_b;
          r_sign_q <= r_a[WIDTH-1] ^ r_b[WIDTH-1];
          r_sign_r <= r_a[WIDTH-1];
          r_rem    <= '0;
          r_cnt    <= '0;
          r_state  <= ITER;
        end
        ITER: begin
          r_rem <= w_rem_next;
          r_quo <= w_quo_next;
          if (r_cnt == c_CNT_LAST) begin
            r_cnt   <= '0;
            r_state <= FIX;
          end else begin
            r_cnt <= r_cnt + c_CNT_ONE;
          end
        end
        FIX: begin
          lo      <= r_sign_q ? (-r_quo) : r_quo;
          hi      <= r_sign_r ? (-r_rem) : r_rem;
          done    <= 1'b1;
          r_state <= DONE;
        end
        DONE: begin
          busy    <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          busy    <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_div_seq_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_div_seq_unit
// Brief   : Scoreboard bench for div_seq_unit. The driver pushes hand-computed
//           results when it issues a division; a monitor pops and compares
//           whenever done is presented.
// Revision: 1.0 - initial release
// ============================================================================
module tb_div_seq_unit;

  localparam int W       = 32;
  localparam int LAT_DIV = W + 3;
  localparam int LAT_DZ  = 1;

  typedef struct {
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    logic         exc;
    int           acc;
    int           lat;
  } exp_t;

  logic         clk;
  logic         reset;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         init;
  logic [W-1:0] lo;
  logic [W-1:0] hi;
  logic         excessao;
  logic         done;
  logic         busy;

  int   total;
  int   bad;
  int   cyc;
  bit   chk_fall;
  exp_t sb[$];

  div_seq_unit #(
    .WIDTH (W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .a        (a),
    .b        (b),
    .init     (init),
    .lo       (lo),
    .hi       (hi),
    .excessao (excessao),
    .done     (done),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: pop and compare whenever the DUT presents done.
  initial begin
    exp_t e;
    chk_fall = 1'b0;
    forever begin
      @(negedge clk);
      if (chk_fall) begin
        chk_fall = 1'b0;
        chk("done_one_cycle", {31'b0, done}, 32'd0);
        chk("busy_falls_with_done", {31'b0, busy}, 32'd0);
      end
      if (excessao && !done) begin
        total++;
        bad++;
        $display("FAIL excessao_without_done actual=1 required=0 (t=%0t)", $time);
      end
      if (done) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done actual=1 required=0 lo=%h hi=%h (t=%0t)", lo, hi, $time);
        end else begin
          e = sb.pop_front();
          chk("lo", lo, e.lo);
          chk("hi", hi, e.hi);
          chk("excessao", {31'b0, excessao}, {31'b0, e.exc});
          chk("latency", 32'(cyc - e.acc + 1), 32'(e.lat));
          chk_fall = 1'b1;
        end
      end
    end
  end

  // Wait (bounded) until the DUT is back in IDLE.
  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy || done) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (busy || done) begin
      total++;
      bad++;
      $display("FAIL idle_timeout actual=busy required=idle (t=%0t)", $time);
    end
  endtask

  // Issue one division at a negedge and register the expected result.
  task automatic issue(input logic [W-1:0] da, input logic [W-1:0] db,
                       input logic [W-1:0] elo, input logic [W-1:0] ehi,
                       input logic eexc, input bit push);
    exp_t e;
    a    = da;
    b    = db;
    init = 1'b1;
    if (push) begin
      e.lo  = elo;
      e.hi  = ehi;
      e.exc = eexc;
      e.acc = cyc + 1;
      e.lat = eexc ? LAT_DZ : LAT_DIV;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    init = 1'b0;
    a    = $urandom;
    b    = $urandom;
  endtask

  task automatic run_div(input logic [W-1:0] da, input logic [W-1:0] db,
                         input logic [W-1:0] elo, input logic [W-1:0] ehi,
                         input logic eexc);
    wait_idle();
    @(negedge clk);
    issue(da, db, elo, ehi, eexc, 1'b1);
    @(negedge clk);
    chk("busy_after_accept", {31'b0, busy}, 32'd1);
    wait_idle();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    cyc   = 0;
    reset = 1'b1;
    init  = 1'b0;
    a     = '0;
    b     = '0;
    repeat (2) @(negedge clk);
    chk("reset_lo", lo, 32'd0);
    chk("reset_hi", hi, 32'd0);
    chk("reset_done", {31'b0, done}, 32'd0);
    chk("reset_exc", {31'b0, excessao}, 32'd0);
    chk("reset_busy", {31'b0, busy}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Directed vectors: a, b, expected lo, expected hi, expected exception.
    run_div(32'd7,          32'd2,          32'd3,          32'd1,          1'b0);
    run_div(32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0);
    run_div(32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          1'b0);
    run_div(32'd100,        32'd7,          32'd14,         32'd2,          1'b0);
    run_div(32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         32'hFFFF_FFFE,  1'b0);
    run_div(32'd0,          32'd5,          32'd0,          32'd0,          1'b0);
    run_div(32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          32'hFFFF_FFFF,  1'b0);
    run_div(32'h8000_0000,  32'd1,          32'h8000_0000,  32'd0,          1'b0);
    run_div(32'h7FFF_FFFF,  32'h7FFF_FFFF,  32'd1,          32'd0,          1'b0);
    run_div(32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1'b0);
    run_div(32'd59,         32'd10,         32'd5,          32'd9,          1'b0);
    run_div(32'd5,          32'd0,          32'd5,          32'd9,          1'b1);

    // init while busy (mid-ITER) must be ignored.
    wait_idle();
    @(negedge clk);
    issue(32'd7, 32'd2, 32'd3, 32'd1, 1'b0, 1'b1);
    repeat (10) @(negedge clk);
    a    = 32'd1;
    b    = 32'd1;
    init = 1'b1;
    @(negedge clk);
    init = 1'b0;
    wait_idle();
    repeat (3) @(negedge clk);

    // Reset during ITER cycle 10 aborts with no done pulse.
    @(negedge clk);
    issue(32'd100, 32'd7, 32'd0, 32'd0, 1'b0, 1'b0);
    repeat (11) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("abort_lo", lo, 32'd0);
    chk("abort_hi", hi, 32'd0);
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_done", {31'b0, done}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (W + 8) @(negedge clk);
    chk("idle_after_abort", {31'b0, busy}, 32'd0);

    // Sanity after abort: a fresh division works.
    run_div(32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
    repeat (4) @(negedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
